// File: rtl/serial_frame_rx.sv
// Serial frame receiver: one bit per clock, start/data/optional even parity/stop,
// single-entry holding register with sticky parity, framing and overrun flags.
module serial_frame_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              D_IN,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  input  logic              Q_ACK,
  output logic              BUSY,
  output logic              PAR_ERR,
  output logic              FRM_ERR,
  output logic              OVR_ERR
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0]   shift, shift_nxt;
  logic                bad, bad_nxt;
  logic [DATA_W-1:0]   q_nxt;
  logic                q_valid_nxt;
  logic                busy_nxt;
  logic                par_err_nxt;
  logic                frm_err_nxt;
  logic                ovr_err_nxt;

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      bad     <= 1'b0;
      Q       <= '0;
      Q_VALID <= 1'b0;
      BUSY    <= 1'b0;
      PAR_ERR <= 1'b0;
      FRM_ERR <= 1'b0;
      OVR_ERR <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      bad     <= bad_nxt;
      Q       <= q_nxt;
      Q_VALID <= q_valid_nxt;
      BUSY    <= busy_nxt;
      PAR_ERR <= par_err_nxt;
      FRM_ERR <= frm_err_nxt;
      OVR_ERR <= ovr_err_nxt;
    end
  end

  // Next-state, datapath and holding-register decisions
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    bad_nxt     = bad;
    q_nxt       = Q;
    q_valid_nxt = Q_VALID;
    par_err_nxt = PAR_ERR;
    frm_err_nxt = FRM_ERR;
    ovr_err_nxt = OVR_ERR;

    // Consumer ack frees the holding register; a same-edge delivery below re-fills it
    if (Q_VALID && Q_ACK) begin
      q_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!D_IN) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          bad_nxt     = 1'b0;
        end
      end

      DATA: begin
        shift_nxt[bit_cnt] = D_IN;
        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end

      PARITY: begin
        if (D_IN != (^shift)) begin
          bad_nxt     = 1'b1;
          par_err_nxt = 1'b1;
        end
        state_nxt = STOP;
      end

      STOP: begin
        if (D_IN) begin
          state_nxt = IDLE;
          if (!bad) begin
            if (Q_VALID && !Q_ACK) begin
              ovr_err_nxt = 1'b1;
            end else begin
              q_nxt       = shift;
              q_valid_nxt = 1'b1;
            end
          end
        end else begin
          frm_err_nxt = 1'b1;
          state_nxt   = WAIT_HIGH;
        end
      end

      WAIT_HIGH: begin
        // A line held low after a bad stop must not look like a new start bit
        if (D_IN) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed scenarios plus randomized
// frames compared against a frame-level behavioural model.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       d_in;
  logic       q_ack;
  logic [7:0] q;
  logic       q_valid, busy, par_err, frm_err, ovr_err;

  logic       d4;
  logic       ack4;
  logic [3:0] q4;
  logic       qv4, busy4, pe4, fe4, oe4;

  int errors;
  int checks;

  // frame-level reference model state
  logic [7:0] m_q;
  logic       m_qv, m_par, m_frm, m_ovr;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .CLK(clk), .RST_N(rst_n), .D_IN(d_in), .Q(q), .Q_VALID(q_valid),
    .Q_ACK(q_ack), .BUSY(busy), .PAR_ERR(par_err), .FRM_ERR(frm_err),
    .OVR_ERR(ovr_err)
  );

  serial_frame_rx #(.DATA_W(4), .PARITY_EN(0)) dut4 (
    .CLK(clk), .RST_N(rst_n), .D_IN(d4), .Q(q4), .Q_VALID(qv4),
    .Q_ACK(ack4), .BUSY(busy4), .PAR_ERR(pe4), .FRM_ERR(fe4),
    .OVR_ERR(oe4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // one clock with the given line level and ack; outputs readable on return
  task automatic step(input logic b, input logic ack);
    d_in  = b;
    q_ack = ack;
    @(posedge clk);
    #1;
    q_ack = 1'b0;
  endtask

  task automatic send8(input logic [7:0] data, input logic par_bad,
                       input logic stop_bad, input logic ack_stop);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(data[i], 1'b0);
    step((^data) ^ par_bad, 1'b0);
    step(~stop_bad, ack_stop);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic chk_flags(input string name, input logic pe, input logic fe, input logic oe);
    checks++;
    if ({par_err, frm_err, ovr_err} !== {pe, fe, oe}) begin
      errors++;
      $display("FAIL %s flags: got par/frm/ovr=%b%b%b want %b%b%b", name,
               par_err, frm_err, ovr_err, pe, fe, oe);
    end
  endtask

  task automatic chk_q(input string name, input logic [7:0] exp_q, input logic exp_v);
    checks++;
    if (q !== exp_q || q_valid !== exp_v) begin
      errors++;
      $display("FAIL %s q: got q=%h v=%b want q=%h v=%b", name, q, q_valid, exp_q, exp_v);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk_q("reset", 8'h00, 1'b0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || q4 !== 4'h0 || qv4 !== 1'b0 || busy4 !== 1'b0 ||
        {pe4, fe4, oe4} !== 3'b000) begin
      errors++;
      $display("FAIL reset_misc: got busy=%b q4=%h qv4=%b busy4=%b flags4=%b%b%b want all 0",
               busy, q4, qv4, busy4, pe4, fe4, oe4);
    end
  endtask

  task automatic test_basic();
    logic [7:0] data;
    data = 8'hA5;
    step(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    for (int i = 0; i < 8; i++) step(data[i], 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (q_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: got q_valid=%b want 0 before stop edge", q_valid);
    end
    step(1'b1, 1'b0);
    chk_q("basic", 8'hA5, 1'b1);
    chk_flags("basic", 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b want 0", busy);
    end
    step(1'b1, 1'b0);
    chk_q("basic_hold", 8'hA5, 1'b1);
    step(1'b1, 1'b1);
    chk_q("basic_ack", 8'hA5, 1'b0);
  endtask

  task automatic test_parity();
    send8(8'h3C, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_q("parity", 8'hA5, 1'b0);
    chk_flags("parity", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_framing();
    send8(8'h55, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL framing_hold: got busy=%b q_valid=%b want 1 0", busy, q_valid);
    end
    step(1'b1, 1'b0);
    chk_q("framing_drop", 8'hA5, 1'b0);
    send8(8'h0F, 1'b0, 1'b0, 1'b0);
    chk_q("framing_next", 8'h0F, 1'b1);
    chk_flags("framing", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send8(8'h11, 1'b0, 1'b0, 1'b0);
    send8(8'h22, 1'b0, 1'b0, 1'b0);
    chk_q("b2b_ovr", 8'h11, 1'b1);
    chk_flags("b2b_ovr", 1'b0, 1'b0, 1'b1);
    do_reset();
    send8(8'h11, 1'b0, 1'b0, 1'b0);
    send8(8'h22, 1'b0, 1'b0, 1'b1);
    chk_q("b2b_ack", 8'h22, 1'b1);
    chk_flags("b2b_ack", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy: got %b want 0", busy);
    end
    step(1'b1, 1'b0);
    send8(8'h81, 1'b0, 1'b0, 1'b0);
    chk_q("midreset", 8'h81, 1'b1);
    chk_flags("midreset", 1'b0, 1'b0, 1'b0);
    // low pulse entirely between edges must not reset anything
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    chk_q("rst_glitch", 8'h81, 1'b1);
  endtask

  task automatic test_nopar();
    logic [3:0] data;
    data = 4'hB;
    d4 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      d4 = data[i];
      @(posedge clk); #1;
    end
    checks++;
    if (qv4 !== 1'b0) begin
      errors++;
      $display("FAIL nopar_early: got qv=%b want 0", qv4);
    end
    d4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q4 !== 4'hB || qv4 !== 1'b1 || {pe4, fe4, oe4} !== 3'b000) begin
      errors++;
      $display("FAIL nopar: got q=%h v=%b flags=%b%b%b want q=b v=1 flags=000",
               q4, qv4, pe4, fe4, oe4);
    end
  endtask

  task automatic test_random();
    logic [7:0] data;
    logic       par_bad, stop_bad, ack, good;
    int         gap;
    do_reset();
    m_q = 8'h00; m_qv = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    for (int f = 0; f < 40; f++) begin
      data     = 8'($urandom);
      par_bad  = ($urandom_range(4) == 0);
      stop_bad = ($urandom_range(5) == 0);
      ack      = 1'($urandom);
      send8(data, par_bad, stop_bad, ack);
      good = !par_bad && !stop_bad;
      if (par_bad)  m_par = 1'b1;
      if (stop_bad) m_frm = 1'b1;
      if (good) begin
        if (m_qv && !ack) m_ovr = 1'b1;
        else begin
          m_q  = data;
          m_qv = 1'b1;
        end
      end else if (ack) begin
        m_qv = 1'b0;
      end
      checks++;
      if (q !== m_q || q_valid !== m_qv) begin
        errors++;
        $display("FAIL rand_q frame %0d: got q=%h v=%b want q=%h v=%b", f, q, q_valid, m_q, m_qv);
      end
      checks++;
      if ({par_err, frm_err, ovr_err} !== {m_par, m_frm, m_ovr}) begin
        errors++;
        $display("FAIL rand_flags frame %0d: got %b%b%b want %b%b%b", f,
                 par_err, frm_err, ovr_err, m_par, m_frm, m_ovr);
      end
      gap = $urandom_range(2);
      if (stop_bad && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        ack = ($urandom_range(2) == 0);
        step(1'b1, ack);
        if (ack) m_qv = 1'b0;
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    d_in   = 1'b1;
    q_ack  = 1'b0;
    d4     = 1'b1;
    ack4   = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_nopar();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning number of data bits per frame (legal 4..16).
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning 1 = even parity bit present after data, 0 = no parity bit.
REQ-003 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous and active-low, sampled on CLK rising edge.
REQ-005 SHALL have port D_IN  input  1  serial bit stream, driven by the upstream D flip-flop Q output, one bit per CLK, idle level 1.
REQ-006 SHALL have port Q  output  DATA_W  last accepted frame data.
REQ-007 SHALL have port Q_VALID  output  1  Q holds an unconsumed frame.
REQ-008 SHALL have port Q_ACK  input  1  consumer takes Q this cycle, effective only while Q_VALID=1.
REQ-009 SHALL have port BUSY  output  1  frame reception in progress (state not IDLE).
REQ-010 SHALL have port PAR_ERR  output  1  sticky, parity mismatch seen.
REQ-011 SHALL have port FRM_ERR  output  1  sticky, stop bit sampled 0.
REQ-012 SHALL have port OVR_ERR  output  1  sticky, good frame dropped because holding register full.

Function
REQ-013 Frame format SHALL be: start bit 0, DATA_W data bits LSB first, parity bit if PARITY_EN=1, stop bit 1; one bit per CLK, no oversampling.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE: D_IN=0 -> DATA, bit counter cleared; D_IN=1 -> stay IDLE.
REQ-016 DATA: shift D_IN into bit position counter; after bit DATA_W-1 -> PARITY if PARITY_EN=1, else STOP.
REQ-017 PARITY: compare D_IN with XOR of data bits (even parity); mismatch marks frame bad and sets PAR_ERR; -> STOP.
REQ-018 STOP: D_IN=1 -> IDLE, frame delivered if not marked bad; D_IN=0 -> set FRM_ERR, discard frame, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until D_IN=1, then -> IDLE; prevents a held-low line being taken as back-to-back starts.
REQ-020 Delivery latency: Q and Q_VALID SHALL update on the edge that samples the stop bit; Q_VALID visible the following cycle, i.e. DATA_W+2+PARITY_EN cycles after the start-bit edge.
REQ-021 Holding register: Q_VALID stays 1 and Q stable until Q_ACK=1 at a rising edge; then Q_VALID clears next cycle.
REQ-022 Good frame completing while Q_VALID=1 and Q_ACK=0: frame dropped, Q unchanged, OVR_ERR set.
REQ-023 Good frame completing in same cycle as Q_ACK=1: new data loaded, Q_VALID stays 1, no OVR_ERR.
REQ-024 Bad frame (parity or framing) SHALL never change Q or Q_VALID.
REQ-025 Q_ACK with Q_VALID=0 SHALL be ignored.
REQ-026 Sticky error flags SHALL clear only on reset.
REQ-027 Start-bit detection in IDLE SHALL be possible the cycle immediately after the stop bit (back-to-back frames).

Reset
REQ-028 RST_N=0 at a rising edge SHALL force state IDLE, bit counter 0, shift register 0, Q=0, Q_VALID=0, BUSY=0, PAR_ERR=0, FRM_ERR=0, OVR_ERR=0.
REQ-029 Reset mid-frame SHALL abandon the partial frame with no delivery; reception resumes from IDLE on the first D_IN=0 after RST_N=1.
REQ-030 No asynchronous reset path; RST_N changes between edges SHALL have no effect.

Verification
REQ-031 DATA_W=8, PARITY_EN=1: send start, 0xA5 LSB first, parity 0, stop 1 -> Q=0xA5, Q_VALID=1 exactly 11 cycles after start edge, no error flags.
REQ-032 Send 0x3C with parity 1 (wrong) -> PAR_ERR=1, Q and Q_VALID unchanged.
REQ-033 Send 0x55 with stop bit 0, hold D_IN=0 for 5 more cycles, then 1, then frame 0x0F -> FRM_ERR=1, no delivery for 0x55, Q=0x0F delivered afterwards.
REQ-034 Back-to-back 0x11 then 0x22 with Q_ACK=0 -> Q=0x11 retained, OVR_ERR=1; repeat with Q_ACK=1 on 0x22 stop-bit edge -> Q=0x22, Q_VALID=1, OVR_ERR stays 0 after reset.
REQ-035 Assert RST_N=0 for one edge after 4 data bits of 0xFF, then send 0x81 -> only Q=0x81 delivered, all flags 0.
REQ-036 PARITY_EN=0, DATA_W=4: send 0xB -> Q=0xB, Q_VALID 6 cycles after start edge.
